// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO read-side drain engine.
//
//   Contents:
//     DATA_W_DEF / ADDR_W_DEF : default word width and FIFO address width
//     drain_state_t           : drain engine FSM states
//     ptr_t                   : FIFO pointer / counter type (ADDR_W_DEF+1 bits)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    // One bit wider than the address so a full FIFO's worth can be counted.
    typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_skid2.sv
// -----------------------------------------------------------------------------
// fifo_skid2
//   Two-entry in-order skid buffer between the storage read port and the
//   downstream valid/ready interface.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-low reset
//     push       in   write push_data this cycle
//     push_data  in   word to write
//     pop        in   head consumed this cycle (only when valid)
//     occ        out  number of stored words (0..2)
//     head       out  oldest stored word; stable until popped
//     valid      out  occ != 0
// -----------------------------------------------------------------------------
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head,
    output logic              valid
);

    logic [1:0]        occ_q,  occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                // Fill head first so the oldest word is always in head_q.
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop: occupancy unchanged, queue shifts.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ   = occ_q;
    assign head  = head_q;
    assign valid = (occ_q != 2'd0);

    // The upstream credit rule keeps at most two words outstanding, so a push
    // into a full buffer without a pop would silently drop data.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (occ_q == 2'd2)));

    // Pops are only legal while a word is present.
    assert property (@(posedge clk) disable iff (!rst)
        !(pop && (occ_q == 2'd0)));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
//   Read-side engine for the FIFO controller. Issues read strobes while the
//   FIFO is non-empty and downstream credit exists, captures the storage read
//   data one cycle later, and forwards words through a 2-entry skid buffer.
//   Supports counted bursts (burst_len != 0) or drain-until-empty
//   (burst_len == 0), an abort pulse and a sticky underflow error.
//
//   Handshake: a word transfers downstream on every rising edge where
//   out_valid && out_ready; out_data is held stable while out_valid is high and
//   out_ready is low; out_valid never drops without a transfer.
//
//   Ports:
//     clk            in   clock, rising edge
//     rst            in   asynchronous active-low reset (0 = reset)
//     start          in   one-cycle pulse, honoured only in IDLE
//     abort          in   one-cycle pulse, stop issuing reads
//     burst_len      in   words to read, 0 = until empty; sampled on start
//     emp            in   FIFO empty flag
//     underflow      in   FIFO underflow flag
//     rd             out  read strobe to FIFO controller (combinational)
//     rd_data        in   storage data, valid the cycle after rd
//     out_valid      out  downstream data valid
//     out_ready      in   downstream ready
//     out_data       out  downstream data
//     busy           out  engine not idle
//     done           out  one-cycle pulse on burst completion
//     count          out  words delivered in current/last burst
//     err_underflow  out  sticky underflow seen during a drain
//     dbg_state      out  current FSM state
// -----------------------------------------------------------------------------
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              emp,
    input  logic              underflow,
    output logic              rd,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_underflow,
    output drain_state_t      dbg_state
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    drain_state_t    state_q,    state_d;
    logic [ADDR_W:0] len_q,      len_d;
    logic [ADDR_W:0] issued_q,   issued_d;
    logic [ADDR_W:0] count_q,    count_d;
    logic            inflight_q, inflight_d;
    logic            err_q,      err_d;

    logic [1:0]      occ;
    logic            skid_valid;
    logic [DATA_W-1:0] skid_head;
    logic            pop;
    logic [2:0]      credit_need;
    logic            credit_ok;
    logic            len_ok;
    logic            drain_exit;

    // -------------------------------------------------------------------------
    // Skid buffer: the word requested last cycle is written unconditionally;
    // the credit rule below guarantees there is room for it.
    // -------------------------------------------------------------------------
    fifo_skid2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (skid_head),
        .valid     (skid_valid)
    );

    assign pop = skid_valid && out_ready;

    // Words already committed (stored + in flight) after this cycle's pop.
    // Keeping this below two before issuing a read means the new word always
    // has a slot, while still allowing one read per cycle when out_ready=1.
    assign credit_need = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok   = (credit_need < 3'd2);

    assign len_ok = (len_q == '0) || (issued_q < len_q);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        count_d    = count_q;
        err_d      = err_q;
        rd         = 1'b0;
        done       = 1'b0;
        drain_exit = 1'b0;

        // Deliveries can still complete in FLUSH, so count every pop.
        if (pop) begin
            count_d = count_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    count_d  = '0;
                    err_d    = 1'b0;
                    state_d  = DRAIN;
                end
            end

            DRAIN: begin
                rd = !emp && credit_ok && len_ok;
                if (rd) begin
                    issued_d = issued_q + CNT_ONE;
                end
                if (underflow) begin
                    err_d = 1'b1;
                end
                drain_exit = ((len_q != '0) && (issued_q == len_q))
                           || ((len_q == '0) && emp && !rd)
                           || abort
                           || underflow;
                if (drain_exit) begin
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                // Wait until every requested word has left the skid.
                if (!inflight_q && (occ == 2'd0)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A read issued now returns data next cycle.
        inflight_d = rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign out_valid     = skid_valid;
    assign out_data      = skid_head;
    assign busy          = (state_q != IDLE);
    assign count         = count_q;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

    // done is a single-cycle pulse: DONE always returns to IDLE.
    assert property (@(posedge clk) disable iff (!rst) done |=> !done);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
module tb_fifo_drain_ctrl;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          abort;
    logic [AW:0]   burst_len;
    logic          emp;
    logic          underflow;
    logic          rd;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err_underflow;
    drain_state_t  dbg_state;

    fifo_drain_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .burst_len     (burst_len),
        .emp           (emp),
        .underflow     (underflow),
        .rd            (rd),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .count         (count),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state)
    );

    // ---------------------------------------------------------------- model state
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];  // storage contents, head = next word read
    logic [DW-1:0] exp_q[$];   // words read from storage, not yet delivered
    logic [DW-1:0] got_q[$];   // words delivered in the current burst
    logic [DW-1:0] snap_q[$];

    int  cyc        = 0;
    int  n_rd       = 0;
    int  n_done     = 0;
    int  first_rd   = -1;
    int  first_vld  = -1;
    int  rd_run     = 0;
    int  max_rd_run = 0;
    int  cnt_model  = 0;
    int  ready_mode = 1;
    bit  exp_busy   = 1'b0;
    bit  err_exp    = 1'b0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    // ---------------------------------------------------------------- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: sample/check at negedge, then advance the storage model and
    // drive the next cycle's inputs just after the rising edge.
    task automatic cycle();
        bit s_rd;
        bit s_pop;
        bit s_start;
        @(negedge clk);
        cyc++;
        s_rd    = rd;
        s_pop   = out_valid && out_ready;
        s_start = start && rst;

        check("rd_while_empty", 32'(rd & emp), 0);
        check("busy", 32'(busy), 32'(exp_busy));
        check("count", 32'(count), cnt_model % 64);
        check("err_underflow", 32'(err_underflow), 32'(err_exp));
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (s_pop) begin
            check("word_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            got_q.push_back(out_data);
            cnt_model++;
        end
        check("credit_limit", 32'((exp_q.size() + int'(s_rd)) <= 2), 1);

        if (done) n_done++;
        if (s_rd) begin
            n_rd++;
            rd_run++;
            if (rd_run > max_rd_run) max_rd_run = rd_run;
            if (first_rd < 0) first_rd = cyc;
        end else begin
            rd_run = 0;
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;

        if (done) begin
            exp_busy = 1'b0;
        end else if (s_start && !exp_busy) begin
            exp_busy  = 1'b1;
            cnt_model = 0;
            err_exp   = 1'b0;
        end

        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() > 0) begin
            rd_data = fifo_q.pop_front();
            exp_q.push_back(rd_data);
        end else begin
            rd_data = DW'($urandom);
        end
        emp       = (fifo_q.size() == 0);
        start     = 1'b0;
        abort     = 1'b0;
        underflow = 1'b0;
        drive_ready();
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic load(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(rnd ? DW'($urandom) : DW'(base + i));
        end
        emp = (fifo_q.size() == 0);
    endtask

    task automatic begin_burst(input int len);
        logic [31:0] l;
        n_rd       = 0;
        n_done     = 0;
        first_rd   = -1;
        first_vld  = -1;
        rd_run     = 0;
        max_rd_run = 0;
        got_q.delete();
        l         = len;
        burst_len = l[AW:0];
        start     = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) cycle();
        cycle();
        cycle();
        check("done_once", n_done, 1);
        check("idle_after_done", 32'(busy), 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_got(input int base, input int n);
        check("delivered_n", got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < n; i++) begin
            check("delivered_word", 32'(got_q[i]), 32'(base + i));
        end
    endtask

    task automatic reset_outputs_zero();
        check("rst_rd", 32'(rd), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_err", 32'(err_underflow), 0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        int len;
        int k;

        // Reset held with start asserted and data present.
        rst       = 1'b0;
        start     = 1'b1;
        abort     = 1'b0;
        underflow = 1'b0;
        out_ready = 1'b1;
        burst_len = 6'd4;
        rd_data   = '0;
        emp       = 1'b1;
        load(4, 'h10, 1'b0);
        repeat (3) begin
            @(negedge clk);
            reset_outputs_zero();
        end
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        repeat (4) cycle();
        check("no_rd_after_reset", n_rd, 0);
        check("idle_after_reset", 32'(dbg_state), 32'(IDLE));

        // Counted burst, full throughput.
        ready_mode = 1;
        begin_burst(4);
        wait_done(50);
        check("burst_n_rd", n_rd, 4);
        check("burst_rd_consecutive", max_rd_run, 4);
        check("first_valid_latency", first_vld - first_rd, 2);
        check_got('h10, 4);
        check("burst_count", 32'(count), 4);

        // Backpressure: only two words may be requested while stalled.
        load(4, 'h10, 1'b0);
        ready_mode = 0;
        out_ready  = 1'b0;
        begin_burst(4);
        repeat (8) cycle();
        check("stalled_n_rd", n_rd, 2);
        check("stalled_valid", 32'(out_valid), 1);
        check("stalled_head", 32'(out_data), 'h10);
        check("stalled_busy", 32'(busy), 1);
        ready_mode = 1;
        out_ready  = 1'b1;
        wait_done(50);
        check("bp_n_rd", n_rd, 4);
        check_got('h10, 4);
        check("bp_count", 32'(count), 4);

        // Drain until empty.
        load(5, 'h20, 1'b0);
        begin_burst(0);
        wait_done(50);
        check("drain_n_rd", n_rd, 5);
        check_got('h20, 5);
        check("drain_count", 32'(count), 5);

        // Starvation then abort.
        load(3, 'h30, 1'b0);
        begin_burst(8);
        repeat (12) cycle();
        check("starve_n_rd", n_rd, 3);
        check_got('h30, 3);
        check("starve_busy", 32'(busy), 1);
        check("starve_state", 32'(dbg_state), 32'(DRAIN));
        abort = 1'b1;
        wait_done(20);
        check("abort_count", 32'(count), 3);

        // Underflow mid-burst: sticky error, cleared by the next start.
        load(10, 'h40, 1'b0);
        begin_burst(10);
        repeat (3) cycle();
        underflow = 1'b1;
        cycle();
        err_exp = 1'b1;
        wait_done(30);
        check("uf_sticky", 32'(err_underflow), 1);
        check_got('h40, n_rd);
        check("uf_count", 32'(count), n_rd);
        fifo_q.delete();
        emp = 1'b1;
        begin_burst(0);
        wait_done(20);
        check("uf_cleared", 32'(err_underflow), 0);
        check("empty_drain_n_rd", n_rd, 0);
        check("empty_drain_count", 32'(count), 0);

        // Reset with a read in flight: the returning word must be dropped.
        load(4, 'h50, 1'b0);
        begin_burst(4);
        for (int i = 0; i < 10 && n_rd == 0; i++) cycle();
        check("mid_reset_rd_seen", n_rd, 1);
        #2;
        rst = 1'b0;
        #1;
        reset_outputs_zero();
        exp_q.delete();
        exp_busy   = 1'b0;
        cnt_model  = 0;
        err_exp    = 1'b0;
        prev_stall = 1'b0;
        first_vld  = -1;
        repeat (2) cycle();
        rst = 1'b1;
        repeat (5) cycle();
        check("late_word_dropped", first_vld, -1);
        check("mid_reset_idle", 32'(busy), 0);
        fifo_q.delete();
        emp = 1'b1;

        // Full-depth counted burst with random backpressure.
        load(32, 'h80, 1'b0);
        ready_mode = 2;
        begin_burst(32);
        wait_done(400);
        check_got('h80, 32);
        check("depth_count", 32'(count), 32);

        // Randomised bursts.
        for (int it = 0; it < 16; it++) begin
            fifo_q.delete();
            n = $urandom_range(0, 12);
            load(n, 0, 1'b1);
            snap_q = fifo_q;
            if (n == 0 || $urandom_range(0, 1) == 0) len = 0;
            else len = $urandom_range(1, n);
            k = (len == 0) ? n : len;
            ready_mode = 2;
            begin_burst(len);
            wait_done(300);
            check("rand_count", 32'(count), k);
            check("rand_n", got_q.size(), k);
            for (int i = 0; i < got_q.size() && i < k; i++) begin
                check("rand_word", 32'(got_q[i]), 32'(snap_q[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
